// File: rtl/brq_prefetch_buffer.sv
// Instruction prefetch unit: issues req/gnt/rvalid fetches, buffers returns in a Depth-entry FIFO for decode.
// Latency: a return in cycle t is visible on fb_* in cycle t+1; a redirect in t shows its first entry at t+3 at best.
// Backpressure: queued + in-flight fetches never exceed Depth, so a stalled decode throttles imem_req.
module brq_prefetch_buffer #(
    parameter int unsigned          DataWidth = 32,
    parameter int unsigned          AddrWidth = 15,
    parameter int unsigned          Depth     = 4,
    parameter logic [DataWidth-1:0] ResetPc   = '0
) (
    input  logic                         brq_clk,
    input  logic                         brq_rst,
    output logic                         imem_req,
    output logic [AddrWidth-1:0]         imem_addr,
    input  logic                         imem_gnt,
    input  logic                         imem_rvalid,
    input  logic [DataWidth-1:0]         imem_rdata,
    input  logic                         redirect_en,
    input  logic [DataWidth-1:0]         redirect_pc,
    output logic                         fb_valid,
    output logic [DataWidth-1:0]         fb_inst,
    output logic [DataWidth-1:0]         fb_pc,
    input  logic                         fb_ready,
    output logic [$clog2(Depth+1)-1:0]   fb_count
);

    localparam int unsigned     CntW     = $clog2(Depth + 1);
    localparam int unsigned     PtrW     = $clog2(Depth);
    localparam logic [CntW:0]   DepthLim = (CntW + 1)'(Depth);

    typedef struct packed {
        logic [DataWidth-1:0] inst;
        logic [DataWidth-1:0] pc;
    } entry_t;

    entry_t                 mem [Depth];
    logic [PtrW-1:0]        rd_ptr;
    logic [PtrW-1:0]        wr_ptr;
    logic [CntW-1:0]        count;
    logic [CntW-1:0]        outstanding;
    logic [CntW-1:0]        discard;
    logic [DataWidth-1:0]   fetch_pc;
    logic [DataWidth-1:0]   rsp_pc;
    logic                   run;

    logic [CntW:0]          credit_used;
    logic                   grant;
    logic                   rsp;
    logic                   push;
    logic                   pop;
    logic [DataWidth-1:0]   redirect_base;

    // run holds the request off for the cycle in which reset is released
    assign credit_used   = {1'b0, count} + {1'b0, outstanding};
    assign imem_req      = run && !redirect_en && (credit_used < DepthLim);
    assign imem_addr     = fetch_pc[AddrWidth+1:2];
    assign grant         = imem_req && imem_gnt;
    assign rsp           = imem_rvalid && (outstanding != '0);
    assign push          = rsp && (discard == '0) && !redirect_en;
    assign pop           = fb_valid && fb_ready && !redirect_en;
    assign redirect_base = redirect_pc & ~DataWidth'(3);

    assign fb_valid = (count != '0);
    assign fb_count = count;
    assign fb_inst  = mem[rd_ptr].inst;
    assign fb_pc    = mem[rd_ptr].pc;

    always_ff @(posedge brq_clk or negedge brq_rst) begin
        if (!brq_rst) begin
            run         <= 1'b0;
            fetch_pc    <= ResetPc;
            rsp_pc      <= ResetPc;
            outstanding <= '0;
            discard     <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            for (int unsigned i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
        end else begin
            run         <= 1'b1;
            outstanding <= outstanding + CntW'(grant) - CntW'(rsp);
            if (redirect_en) begin
                // every request still in flight after this cycle belongs to the old stream
                fetch_pc <= redirect_base;
                rsp_pc   <= redirect_base;
                discard  <= outstanding - CntW'(rsp);
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (grant) begin
                    fetch_pc <= fetch_pc + DataWidth'(4);
                end
                if (rsp && (discard != '0)) begin
                    discard <= discard - CntW'(1);
                end
                if (push) begin
                    mem[wr_ptr] <= '{inst: imem_rdata, pc: rsp_pc};
                    wr_ptr      <= wr_ptr + PtrW'(1);
                    rsp_pc      <= rsp_pc + DataWidth'(4);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PtrW'(1);
                end
                count <= count + CntW'(push) - CntW'(pop);
            end
        end
    end

    rvalid_needs_request: assert property (@(posedge brq_clk) disable iff (!brq_rst)
        imem_rvalid |-> (outstanding != '0));

    push_never_overflows: assert property (@(posedge brq_clk) disable iff (!brq_rst)
        push |-> ((count != CntW'(Depth)) || pop));

endmodule

// File: tb/tb_brq_prefetch_buffer.sv
// Directed bench for brq_prefetch_buffer: memory responder with programmable latency,
// queue-based reference model compared every cycle, plus literal checks per scenario.
module tb_brq_prefetch_buffer;

    localparam int Depth = 4;

    logic         brq_clk = 1'b0;
    logic         brq_rst = 1'b1;
    logic         imem_req;
    logic [14:0]  imem_addr;
    logic         imem_gnt = 1'b0;
    logic         imem_rvalid = 1'b0;
    logic [31:0]  imem_rdata = '0;
    logic         redirect_en = 1'b0;
    logic [31:0]  redirect_pc = '0;
    logic         fb_valid;
    logic [31:0]  fb_inst;
    logic [31:0]  fb_pc;
    logic         fb_ready = 1'b0;
    logic [2:0]   fb_count;

    brq_prefetch_buffer #(
        .DataWidth (32),
        .AddrWidth (15),
        .Depth     (Depth),
        .ResetPc   (32'h0)
    ) dut (
        .brq_clk     (brq_clk),
        .brq_rst     (brq_rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .fb_valid    (fb_valid),
        .fb_inst     (fb_inst),
        .fb_pc       (fb_pc),
        .fb_ready    (fb_ready),
        .fb_count    (fb_count)
    );

    always #5 brq_clk = ~brq_clk;

    int vectors = 0;
    int miscompares = 0;

    typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;
    typedef struct { int due; logic [14:0] addr; } pend_t;

    ent_t         q[$];
    pend_t        pend[$];
    int           outst;
    int           disc;
    logic [31:0]  m_fetch;
    logic [31:0]  m_rsp;
    bit           m_run;
    int           cyc;
    int           grant_cnt;

    int           lat = 1;
    bit           gnt_en = 1'b1;
    bit           rdy = 1'b1;
    bit           redir = 1'b0;
    logic [31:0]  redir_pc = '0;

    function automatic logic [31:0] word(input logic [14:0] a);
        return {~a, 2'b10, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: compare outputs, drive inputs, compare request, advance model and memory.
    task automatic cycle();
        bit          mreq;
        logic        rv;
        logic [31:0] rd;
        logic [31:0] base;
        chk("fb_valid", 32'(fb_valid), 32'(q.size() > 0));
        chk("fb_count", 32'(fb_count), 32'(q.size()));
        if (q.size() > 0) begin
            chk("fb_pc", fb_pc, q[0].pc);
            chk("fb_inst", fb_inst, q[0].inst);
        end
        fb_ready    = rdy;
        imem_gnt    = gnt_en;
        redirect_en = redir;
        redirect_pc = redir_pc;
        redir       = 1'b0;
        rv = 1'b0;
        rd = '0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            rv = 1'b1;
            rd = word(pend[0].addr);
            void'(pend.pop_front());
        end
        imem_rvalid = rv;
        imem_rdata  = rd;
        #1;
        mreq = m_run && !redirect_en && (q.size() + outst < Depth);
        chk("imem_req", 32'(imem_req), 32'(mreq));
        if (mreq) chk("imem_addr", 32'(imem_addr), 32'(m_fetch[16:2]));
        if (imem_req && imem_gnt) begin
            pend.push_back('{cyc + lat, imem_addr});
            grant_cnt++;
        end
        m_run = 1'b1;
        if (redirect_en) begin
            if (rv && outst > 0) outst--;
            base    = redirect_pc & ~32'h3;
            disc    = outst;
            m_fetch = base;
            m_rsp   = base;
            q.delete();
        end else begin
            if (rdy && q.size() > 0) void'(q.pop_front());
            if (rv && outst > 0) begin
                outst--;
                if (disc > 0) disc--;
                else begin
                    q.push_back('{rd, m_rsp});
                    m_rsp += 32'd4;
                end
            end
            if (mreq && gnt_en) begin
                outst++;
                m_fetch += 32'd4;
            end
        end
        @(posedge brq_clk);
        #1;
        redirect_en = 1'b0;
        imem_rvalid = 1'b0;
        cyc++;
        @(negedge brq_clk);
    endtask

    // Called at a negedge; asserts reset, checks the asynchronous clear, releases at a negedge.
    task automatic do_reset();
        brq_rst     = 1'b0;
        imem_rvalid = 1'b0;
        redirect_en = 1'b0;
        imem_gnt    = 1'b0;
        fb_ready    = 1'b0;
        q.delete();
        pend.delete();
        outst = 0; disc = 0; m_fetch = '0; m_rsp = '0; m_run = 1'b0;
        grant_cnt = 0; redir = 1'b0; cyc = 0;
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(fb_valid), 32'd0);
        chk("rst_count", 32'(fb_count), 32'd0);
        chk("rst_inst", fb_inst, 32'd0);
        chk("rst_pc", fb_pc, 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        repeat (2) @(negedge brq_clk);
        brq_rst = 1'b1;
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 20 && !fb_valid; i++) cycle();
        chk(name, 32'(fb_valid), 32'd1);
    endtask

    initial begin
        @(negedge brq_clk);

        // sequential fetch: pc 0,4,8,12 from the third cycle after release
        lat = 1; gnt_en = 1'b1; rdy = 1'b1;
        do_reset();
        repeat (3) cycle();
        for (int i = 0; i < 4; i++) begin
            chk("seq_valid", 32'(fb_valid), 32'd1);
            chk("seq_pc", fb_pc, 32'(i * 4));
            chk("seq_inst", fb_inst, word(15'(i)));
            cycle();
        end
        repeat (4) cycle();

        // back-pressure: four grants then the request stops
        rdy = 1'b0;
        do_reset();
        repeat (10) cycle();
        chk("bp_grants", 32'(grant_cnt), 32'd4);
        chk("bp_req", 32'(imem_req), 32'd0);
        chk("bp_count", 32'(fb_count), 32'd4);
        rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_drain_pc", fb_pc, 32'(i * 4));
            cycle();
        end
        repeat (3) cycle();
        chk("bp_resume", 32'(grant_cnt > 4), 32'd1);

        // redirect with three fetches in flight at latency 3
        lat = 3; rdy = 1'b1;
        do_reset();
        repeat (4) cycle();
        chk("rd_inflight", 32'(grant_cnt), 32'd3);
        redir = 1'b1; redir_pc = 32'h100;
        cycle();
        chk("rd_count", 32'(fb_count), 32'd0);
        wait_valid("rd_timeout");
        chk("rd_first_pc", fb_pc, 32'h100);
        chk("rd_first_inst", fb_inst, word(15'h40));
        repeat (4) cycle();

        // redirect coinciding with a return, pop requested in the same cycle
        lat = 1; rdy = 1'b0;
        do_reset();
        repeat (4) cycle();
        chk("sim_count_pre", 32'(fb_count), 32'd2);
        rdy = 1'b1; redir = 1'b1; redir_pc = 32'h80;
        cycle();
        chk("sim_count", 32'(fb_count), 32'd0);
        chk("sim_valid", 32'(fb_valid), 32'd0);
        wait_valid("sim_timeout");
        chk("sim_pc", fb_pc, 32'h80);
        repeat (3) cycle();

        // back-to-back redirects, second one with misaligned low bits
        lat = 3; rdy = 1'b1;
        do_reset();
        repeat (5) cycle();
        redir = 1'b1; redir_pc = 32'h200;
        cycle();
        redir = 1'b1; redir_pc = 32'h303;
        cycle();
        wait_valid("b2b_timeout");
        chk("b2b_pc", fb_pc, 32'h300);
        chk("b2b_inst", fb_inst, word(15'hC0));
        repeat (6) cycle();

        // grant wait-states: request and address hold until granted
        lat = 1; rdy = 1'b1; gnt_en = 1'b0;
        do_reset();
        cycle();
        chk("ws_req0", 32'(imem_req), 32'd1);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("ws_req", 32'(imem_req), 32'd1);
            chk("ws_addr", 32'(imem_addr), 32'd0);
        end
        gnt_en = 1'b1;
        cycle();
        gnt_en = 1'b0;
        chk("ws_addr_next", 32'(imem_addr), 32'd1);
        chk("ws_grants", 32'(grant_cnt), 32'd1);
        repeat (3) cycle();
        gnt_en = 1'b1;

        // mid-operation reset with the FIFO half full
        lat = 1; rdy = 1'b0;
        do_reset();
        repeat (4) cycle();
        chk("mr_count_pre", 32'(fb_count), 32'd2);
        do_reset();
        rdy = 1'b1;
        repeat (3) cycle();
        chk("mr_valid", 32'(fb_valid), 32'd1);
        chk("mr_pc", fb_pc, 32'h0);
        repeat (4) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
